// File: rtl/demux8_pkg.sv
// Shared constants for the eight-way stream demultiplexer.
package demux8_pkg;
    localparam int NUM_CH        = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 32;
    localparam int COUNT_W       = 16;
endpackage

// File: rtl/demux8_slot.sv
// One-entry holding register for a single output channel.
// A load always wins over a drain, so a same-cycle drain and load keeps the
// channel valid with the new word.
import demux8_pkg::*;

module demux8_slot #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // Hold register: capture on load, clear valid on drain, data kept on drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux8_stream.sv
// Eight-way registered demultiplexer: routes one input word per cycle into
// the holding register of the channel named by in_select.
// Optional feature macro: DEMUX8_BCAST_EN enables broadcast via in_bcast,
// which loads all eight channels at once when every channel is free.
import demux8_pkg::*;

module demux8_stream #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_select,
    input  logic                      in_bcast,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0]        xfer_count
);

    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              bcast_req;
    logic              accept;

`ifdef DEMUX8_BCAST_EN
    assign bcast_req = in_bcast;
`else
    // Broadcast is compiled out; the input is intentionally left unused.
    logic unused_bcast;
    assign unused_bcast = in_bcast;
    assign bcast_req    = 1'b0;
`endif

    assign free = ~out_valid | out_ready;

    // Ready generation: forced low during reset so a reset-cycle word is dropped.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (bcast_req) in_ready = &free;
            else           in_ready = free[in_select];
        end
    end

    assign accept = in_valid && in_ready;

    // Select decode: one-hot load for unicast, all channels for broadcast.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (bcast_req || (in_select == SEL_W'(k)));
        end
    end

    // Accepted-transfer counter, wraps naturally at its width.
    always_ff @(posedge clock) begin
        if (reset)       xfer_count <= '0;
        else if (accept) xfer_count <= xfer_count + 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux8_slot #(.WIDTH(WIDTH)) u_slot (
            .clock     (clock),
            .reset     (reset),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux8_stream.sv
// Self-checking bench for demux8_stream against a channel-array reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_demux8_stream;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [2:0]    in_select;
    logic          in_bcast;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [8*W-1:0] out_data;
    logic [15:0]   xfer_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_valid [8];
    logic [W-1:0]  m_data  [8];
    int            m_count;
    logic          exp_rdy;

    demux8_stream #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_bcast   (in_bcast),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    always #5 clock = ~clock;

    function automatic logic model_bcast();
`ifdef DEMUX8_BCAST_EN
        return in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_valid_vec();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_valid[k];
        return v;
    endfunction

    // Drive inputs and derive the expected ready from the model.
    task automatic apply(input logic rst, input logic v, input logic [2:0] sel,
                         input logic [W-1:0] d, input logic bc, input logic [7:0] ordy);
        logic all_free;
        reset = rst; in_valid = v; in_select = sel; in_data = d;
        in_bcast = bc; out_ready = ordy;
        all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (m_valid[k] && !ordy[k]) all_free = 1'b0;
        if (rst)               exp_rdy = 1'b0;
        else if (model_bcast()) exp_rdy = all_free;
        else                   exp_rdy = !m_valid[sel] || ordy[sel];
        #1;
    endtask

    // Advance one clock and update the model from the driven inputs.
    task automatic tick();
        logic acc;
        @(posedge clock);
        acc = in_valid && exp_rdy;
        if (reset) begin
            for (int k = 0; k < 8; k++) begin m_valid[k] = 0; m_data[k] = '0; end
            m_count = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (acc && (model_bcast() || in_select == 3'(k))) begin
                    m_valid[k] = 1'b1; m_data[k] = in_data;
                end else if (out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (acc) m_count = (m_count + 1) % 65536;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1, 1, 3'd2, 32'hCAFE0000 + c, 0, 8'h00);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready got %0b want 0", in_ready);
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (out_valid !== 8'h00 || xfer_count !== 16'h0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state valid %h count %h data_nonzero %0b want 00/0000/0",
                     out_valid, xfer_count, out_data != '0);
        end
    endtask

    task automatic test_unicast_stall();
        apply(0, 1, 3'd3, 32'hDEADBEEF, 0, 8'h00);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 8'h08 || out_data[3*W +: W] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stall_ch3 valid %h data %h want 08 DEADBEEF", out_valid, out_data[3*W +: W]);
        end
        apply(0, 1, 3'd3, 32'h0BADF00D, 0, 8'h00);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_second_ready got %0b want 0", in_ready); end
        tick();
        apply(0, 1, 3'd5, 32'h12345678, 0, 8'h00);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ch5_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 8'h28 || out_data[5*W +: W] !== 32'h12345678 ||
            out_data[3*W +: W] !== 32'hDEADBEEF || xfer_count !== 16'd2) begin
            errors++; $display("FAIL stall_ch5 valid %h d5 %h d3 %h count %0d want 28 12345678 DEADBEEF 2",
                               out_valid, out_data[5*W +: W], out_data[3*W +: W], xfer_count);
        end
        apply(0, 0, 0, 0, 0, 8'hFF);
        tick();
        checks++;
        if (out_valid !== 8'h00 || out_data[3*W +: W] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL drain_all valid %h d3 %h want 00 DEADBEEF", out_valid, out_data[3*W +: W]);
        end
    endtask

    task automatic test_back_to_back();
        apply(1, 0, 0, 0, 0, 8'h00); tick();
        for (int i = 1; i <= 16; i++) begin
            apply(0, 1, 3'd6, 32'(i), 0, 8'h40);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready word %0d got %0b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 8'h40 || out_data[6*W +: W] !== 32'(i)) begin
                errors++; $display("FAIL b2b_word %0d valid %h data %h want 40 %h", i, out_valid, out_data[6*W +: W], i);
            end
        end
        checks++;
        if (xfer_count !== 16'd16) begin errors++; $display("FAIL b2b_count got %0d want 16", xfer_count); end
    endtask

    task automatic test_drain_load();
        apply(0, 1, 3'd2, 32'hA, 0, 8'h00); tick();
        apply(0, 1, 3'd2, 32'hB, 0, 8'h04);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_load_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 32'hB || xfer_count !== 16'(m_count)) begin
            errors++; $display("FAIL drain_load v2 %0b d2 %h count %0d want 1 B %0d",
                               out_valid[2], out_data[2*W +: W], xfer_count, m_count);
        end
        apply(0, 0, 0, 0, 0, 8'hFF); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 3) == 0), 8'($urandom));
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc %0d got %0b want %0b", c, in_ready, exp_rdy); end
            tick();
            checks++;
            if (out_valid !== model_valid_vec() || xfer_count !== 16'(m_count)) begin
                errors++; $display("FAIL rand_state cyc %0d valid %h count %0d want %h %0d",
                                   c, out_valid, xfer_count, model_valid_vec(), m_count);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (out_data[k*W +: W] !== m_data[k]) begin
                    errors++; $display("FAIL rand_data cyc %0d ch %0d got %h want %h", c, k, out_data[k*W +: W], m_data[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply(1, 0, 0, 0, 0, 8'h00); tick();
        for (int i = 0; i < 65535; i++) begin
            apply(0, 1, 3'(i % 8), 32'(i), 0, 8'hFF);
            tick();
        end
        checks++;
        if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want FFFF", xfer_count); end
        apply(0, 1, 3'd0, 32'h1, 0, 8'hFF); tick();
        checks++;
        if (xfer_count !== 16'h0000) begin errors++; $display("FAIL wrap_post got %h want 0000", xfer_count); end
    endtask

    task automatic test_bcast();
        apply(1, 0, 0, 0, 0, 8'h00); tick();
        apply(0, 1, 3'd1, 32'h11, 0, 8'h00); tick();
        apply(0, 1, 3'd4, 32'h55, 1, 8'h00);
`ifdef DEMUX8_BCAST_EN
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_blocked got %0b want 0", in_ready); end
        tick();
        apply(0, 1, 3'd4, 32'h55, 1, 8'h02);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 8'hFF || out_data !== {8{32'h55}} || xfer_count !== 16'd2) begin
            errors++; $display("FAIL bcast_load valid %h count %0d want FF 2", out_valid, xfer_count);
        end
`else
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL nobcast_ready got %0b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 8'h12 || out_data[4*W +: W] !== 32'h55 || out_data[1*W +: W] !== 32'h11 ||
            out_data[0 +: W] !== 32'h0 || xfer_count !== 16'd2) begin
            errors++; $display("FAIL nobcast_load valid %h d4 %h d1 %h count %0d want 12 55 11 2",
                               out_valid, out_data[4*W +: W], out_data[1*W +: W], xfer_count);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        apply(0, 1, 3'd7, 32'h77, 0, 8'h00); tick();
        apply(1, 1, 3'd0, 32'h99, 0, 8'h00);
        tick();
        apply(0, 0, 0, 0, 0, 8'h00);
        checks++;
        if (out_valid !== 8'h00 || xfer_count !== 16'h0 || out_data !== '0) begin
            errors++; $display("FAIL reset_mid valid %h count %0d want 00 0", out_valid, xfer_count);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin m_valid[k] = 0; m_data[k] = '0; end
        m_count = 0;
        reset = 1; in_valid = 0; in_data = '0; in_select = '0; in_bcast = 0; out_ready = '0;
        @(negedge clock);
        test_reset();
        test_unicast_stall();
        test_back_to_back();
        test_drain_load();
        test_bcast();
        test_reset_midstream();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux8_stream.md
# demux8_stream

Eight-way registered demultiplexer carrying one 32-bit input stream to one of eight output channels. It is the distribution counterpart of the processor's 8-to-1 select tree: a producer presents a word plus a 3-bit destination, and the block steers the word into that channel's one-entry holding register. Each channel has independent valid/ready flow control. The block sits between a single write source (writeback or an MMIO bus) and up to eight consumers.

## Interface
- WIDTH, 32, data width of input and of each output channel
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to route
- in_select  input  3  destination channel 0..7
- in_bcast  input  1  broadcast request; used only with DEMUX8_BCAST_EN
- out_valid  output  8  bit k: channel k holds a word
- out_ready  input  8  bit k: consumer k takes the word this cycle
- out_data  output  8*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- xfer_count  output  16  accepted input transfers, wrapping

## Operation
- Channel k is "free" when !out_valid[k] || out_ready[k].
- Unicast (in_bcast low, or macro absent): in_ready = free[in_select]. Accept = in_valid && in_ready.
- On accept: data_k <= in_data and valid_k <= 1 for k = in_select; no other channel changes.
- Drain: out_valid[k] && out_ready[k] with no load into k clears valid_k. data_k keeps its last value.
- Simultaneous drain and load of the same channel: valid_k stays 1, data_k takes the new word, and the old word counts as consumed.
- Other channels drain independently in the same cycle.
- in_select changing while in_valid is high without acceptance is legal. in_ready follows in_select combinationally.
- xfer_count increments by 1 per accept, and by 1 per broadcast accept. It wraps from 0xFFFF to 0x0000.
- Reset: out_valid = 8'h00, out_data = 0, xfer_count = 0.
- in_ready during reset is forced to 0. A word presented in the reset cycle is dropped and not counted.
- Reset mid-stream discards all held words.

## Timing
- Latency: a word accepted in cycle N appears on out_data/out_valid in cycle N+1.
- Throughput: one word per cycle into any channel whose consumer holds out_ready high.
- in_ready depends combinationally on out_ready and in_select, and on in_bcast when enabled. All other outputs are registered.
- No combinational path exists from in_data to out_data.

## Configuration
- DEMUX8_BCAST_EN defined: in_bcast high makes the request a broadcast.
  - in_ready = AND of free[0..7], and in_select is ignored.
  - On accept, all eight channels load in_data and set valid.
- DEMUX8_BCAST_EN undefined: in_bcast is ignored and every request is unicast.

## Structure
- Package demux8_pkg holds NUM_CH = 8, SEL_W = 3, DEFAULT_WIDTH = 32 and COUNT_W = 16.
- Sub-module demux8_slot is the single-channel holding register.
  - Ports: clock, reset, load, load_data, out_ready, out_valid, out_data.
  - Instantiate eight copies. The top level holds the select decode, ready generation and counter.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1 -> out_valid = 0, xfer_count = 0, in_ready = 0, no load.
- Unicast stall: out_ready = 0. Send 0xDEADBEEF to channel 3 -> out_valid = 8'h08 next cycle, and a second send to channel 3 sees in_ready = 0. Send 0x12345678 to channel 5 -> accepted, out_valid = 8'h28.
- Back-to-back flow: out_ready[6] = 1, stream 0x1..0x10 to channel 6 on consecutive cycles -> in_ready held 1, each word on channel 6 one cycle later, xfer_count = 16.
- Simultaneous drain and load: channel 2 holds 0xA, out_ready[2] = 1, send 0xB to channel 2 -> out_valid[2] stays 1, data = 0xB, xfer_count increments.
- Wrap: preload xfer_count to 0xFFFF via 65535 transfers, one more accept -> 0x0000.
- Broadcast (macro on): channel 1 full with out_ready[1] = 0, send in_bcast with 0x55 -> in_ready = 0. Raise out_ready[1] -> accepted, out_valid = 8'hFF, all channels = 0x55, count +1. With the macro off, the same stimulus loads only channel in_select.
